// File: rtl/mem_write_checker.sv
// Self-checking monitor for a core's data-memory write port: matches observed stores
// against a table of expected (address, data) pairs and reports pass, or fail with a reason.
module mem_write_checker #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int NUM_EXP       = 4,
  parameter int TIMEOUT       = 10000,
  parameter int ORDERED       = 1,
  parameter int FAIL_ON_STRAY = 0,
  localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int CNT_W = $clog2(NUM_EXP + 1),
  localparam int CYC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  match_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t                         state, state_d;
  logic [NUM_EXP-1:0][ADDR_W-1:0] tab_addr;
  logic [NUM_EXP-1:0][DATA_W-1:0] tab_data;
  logic [NUM_EXP-1:0]             hit, addr_hit, full_hit, hit_set;
  logic [CYC_W-1:0]               cyc;
  logic [ADDR_W-1:0]              cur_addr;
  logic [DATA_W-1:0]              cur_data;
  logic                           store, is_match, is_mism, store_err, tmo, done;
  logic [1:0]                     err_code;
  logic [CNT_W-1:0]               cnt_nxt;

  assign busy = (state == RUN);
  assign pass = (state == PASS);
  assign fail = (state == FAIL);

  // Per-entry comparators against pending (not yet hit) entries, used in unordered mode.
  for (genvar g = 0; g < NUM_EXP; g++) begin : g_cmp
    assign addr_hit[g] = !hit[g] && (tab_addr[g] == DataAdr);
    assign full_hit[g] = addr_hit[g] && (tab_data[g] == WriteData);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    // In ordered mode the match count doubles as the pointer to the next entry.
    for (int i = 0; i < NUM_EXP; i++) begin
      if (match_cnt == CNT_W'(i)) begin
        cur_addr = tab_addr[i];
        cur_data = tab_data[i];
      end
    end
    hit_set  = '0;
    is_match = 1'b0;
    is_mism  = 1'b0;
    if (ORDERED != 0) begin
      is_match = (cur_addr == DataAdr) && (cur_data == WriteData);
      is_mism  = (cur_addr == DataAdr) && (cur_data != WriteData);
    end else begin
      hit_set  = full_hit & (~full_hit + NUM_EXP'(1));
      is_match = |full_hit;
      is_mism  = !is_match && (|addr_hit);
    end
    store     = (state == RUN) && MemWrite && !start;
    cnt_nxt   = match_cnt + CNT_W'(store && is_match);
    done      = (cnt_nxt == CNT_W'(NUM_EXP));
    store_err = store && !is_match && (is_mism || (FAIL_ON_STRAY != 0));
    err_code  = is_mism ? 2'd1 : 2'd2;
    tmo       = (TIMEOUT != 0) && (cyc == CYC_W'(TIMEOUT - 1));

    state_d = state;
    unique case (state)
      RUN: begin
        if (start)                  state_d = RUN;
        else if (done)              state_d = PASS;
        else if (store_err || tmo)  state_d = FAIL;
      end
      default: if (start) state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tab_addr  <= '0;
      tab_data  <= '0;
      hit       <= '0;
      cyc       <= '0;
      match_cnt <= '0;
      fail_code <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      if (exp_we && state != RUN) begin
        for (int i = 0; i < NUM_EXP; i++) begin
          if (exp_idx == IDX_W'(i)) begin
            tab_addr[i] <= exp_addr;
            tab_data[i] <= exp_data;
          end
        end
      end
      if (start) begin
        hit       <= '0;
        cyc       <= '0;
        match_cnt <= '0;
        fail_code <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (state == RUN) begin
        if (store && is_match) begin
          match_cnt <= cnt_nxt;
          hit       <= hit | hit_set;
        end
        if (TIMEOUT != 0) cyc <= cyc + CYC_W'(1);
        // A completing match takes precedence over any error in the same cycle.
        if (!done && store_err) begin
          fail_code <= err_code;
          fail_addr <= DataAdr;
          fail_data <= WriteData;
        end else if (!done && tmo) begin
          fail_code <= 2'd3;
          fail_addr <= '0;
          fail_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: four differently configured instances share one stimulus
// bus; a behavioural model per instance is compared every cycle, plus literal spot checks.
module tb_mem_write_checker;

  localparam int N = 4;
  localparam int CN [N] = '{1, 2, 2, 2};
  localparam int CO [N] = '{1, 1, 0, 0};
  localparam int CS [N] = '{0, 0, 0, 1};
  localparam int CT [N] = '{10000, 10000, 10000, 50};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  start_v = '0;
  logic        exp_we = 1'b0;
  logic        exp_idx = 1'b0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0, WriteData = '0;

  logic        busy_o [N];
  logic        pass_o [N];
  logic        fail_o [N];
  logic [1:0]  code_o [N];
  logic [31:0] faddr_o [N];
  logic [31:0] fdata_o [N];
  logic [1:0]  mc_o [N];
  logic        mc0;
  logic [1:0]  mc1, mc2, mc3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.NUM_EXP(1), .TIMEOUT(10000), .ORDERED(1), .FAIL_ON_STRAY(0)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .busy(busy_o[0]), .pass(pass_o[0]), .fail(fail_o[0]),
    .fail_code(code_o[0]), .fail_addr(faddr_o[0]), .fail_data(fdata_o[0]), .match_cnt(mc0));
  mem_write_checker #(.NUM_EXP(2), .TIMEOUT(10000), .ORDERED(1), .FAIL_ON_STRAY(0)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .busy(busy_o[1]), .pass(pass_o[1]), .fail(fail_o[1]),
    .fail_code(code_o[1]), .fail_addr(faddr_o[1]), .fail_data(fdata_o[1]), .match_cnt(mc1));
  mem_write_checker #(.NUM_EXP(2), .TIMEOUT(10000), .ORDERED(0), .FAIL_ON_STRAY(0)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .busy(busy_o[2]), .pass(pass_o[2]), .fail(fail_o[2]),
    .fail_code(code_o[2]), .fail_addr(faddr_o[2]), .fail_data(fdata_o[2]), .match_cnt(mc2));
  mem_write_checker #(.NUM_EXP(2), .TIMEOUT(50), .ORDERED(0), .FAIL_ON_STRAY(1)) u3 (
    .clk(clk), .reset(reset), .start(start_v[3]), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .busy(busy_o[3]), .pass(pass_o[3]), .fail(fail_o[3]),
    .fail_code(code_o[3]), .fail_addr(faddr_o[3]), .fail_data(fdata_o[3]), .match_cnt(mc3));

  assign mc_o[0] = {1'b0, mc0};
  assign mc_o[1] = mc1;
  assign mc_o[2] = mc2;
  assign mc_o[3] = mc3;

  // Model state: 0 idle, 1 run, 2 pass, 3 fail.
  int          ms [N];
  int          mm [N];
  int          mcyc [N];
  int          mcode [N];
  logic [31:0] maddr [N];
  logic [31:0] mdata [N];
  logic [31:0] ta [N][2];
  logic [31:0] td [N][2];
  bit          mh [N][2];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin : mdl
      int he;
      bit mis;
      if (reset) begin
        ms[i] <= 0; mm[i] <= 0; mcyc[i] <= 0; mcode[i] <= 0; maddr[i] <= '0; mdata[i] <= '0;
        for (int e = 0; e < 2; e++) begin
          ta[i][e] <= '0; td[i][e] <= '0; mh[i][e] <= 1'b0;
        end
      end else begin
        if (exp_we && ms[i] != 1 && int'(exp_idx) < CN[i]) begin
          ta[i][exp_idx] <= exp_addr;
          td[i][exp_idx] <= exp_data;
        end
        if (start_v[i]) begin
          ms[i] <= 1; mm[i] <= 0; mcyc[i] <= 0; mcode[i] <= 0; maddr[i] <= '0; mdata[i] <= '0;
          for (int e = 0; e < 2; e++) mh[i][e] <= 1'b0;
        end else if (ms[i] == 1) begin
          he = -1;
          mis = 1'b0;
          if (MemWrite) begin
            if (CO[i] != 0) begin
              if (ta[i][mm[i]] == DataAdr) begin
                if (td[i][mm[i]] == WriteData) he = mm[i];
                else mis = 1'b1;
              end
            end else begin
              for (int e = 0; e < CN[i]; e++) begin
                if (!mh[i][e] && ta[i][e] == DataAdr) begin
                  if (td[i][e] == WriteData) begin
                    if (he < 0) he = e;
                  end else mis = 1'b1;
                end
              end
            end
          end
          if (he >= 0) begin
            mh[i][he] <= 1'b1;
            mm[i] <= mm[i] + 1;
          end
          mcyc[i] <= mcyc[i] + 1;
          if (mm[i] + ((he >= 0) ? 1 : 0) == CN[i]) ms[i] <= 2;
          else if (MemWrite && he < 0 && (mis || CS[i] != 0)) begin
            ms[i] <= 3; mcode[i] <= mis ? 1 : 2; maddr[i] <= DataAdr; mdata[i] <= WriteData;
          end else if (CT[i] != 0 && mcyc[i] == CT[i] - 1) begin
            ms[i] <= 3; mcode[i] <= 3; maddr[i] <= '0; mdata[i] <= '0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (busy_o[i] !== (ms[i] == 1) || pass_o[i] !== (ms[i] == 2) || fail_o[i] !== (ms[i] == 3) ||
          code_o[i] !== 2'(mcode[i]) || faddr_o[i] !== maddr[i] || fdata_o[i] !== mdata[i] ||
          mc_o[i] !== 2'(mm[i])) begin
        n_err++;
        $display("FAIL model u%0d @%0t: got b%0b p%0b f%0b c%0d a%0h d%0h m%0d, want b%0b p%0b f%0b c%0d a%0h d%0h m%0d",
                 i, $time, busy_o[i], pass_o[i], fail_o[i], code_o[i], faddr_o[i], fdata_o[i], mc_o[i],
                 ms[i] == 1, ms[i] == 2, ms[i] == 3, mcode[i], maddr[i], mdata[i], mm[i]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic idx, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic load_tab();
    load(1'b0, 32'd100, 32'd25);
    load(1'b1, 32'd104, 32'd26);
  endtask

  task automatic go(input int i);
    start_v[i] = 1'b1;
    tick();
    start_v = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    check("rst busy1", 32'(busy_o[1]), 0);
    check("rst fail3", 32'(fail_o[3]), 0);
    check("rst code3", 32'(code_o[3]), 0);
    check("rst mc2", 32'(mc_o[2]), 0);

    // Single-entry pass; idx 1 is out of range for u0 and must not clobber entry 0.
    load(1'b0, 32'd7, 32'h05ff_05ff);
    load(1'b1, 32'd7, 32'h0);
    go(0);
    check("t1 busy0", 32'(busy_o[0]), 1);
    store(32'd7, 32'h05ff_05ff);
    check("t1 pass0", 32'(pass_o[0]), 1);
    check("t1 mc0", 32'(mc_o[0]), 1);
    check("t1 fail0", 32'(fail_o[0]), 0);

    // Same-cycle load and start.
    do_reset();
    exp_we = 1'b1; exp_idx = 1'b0; exp_addr = 32'd9; exp_data = 32'haa; start_v[0] = 1'b1;
    tick();
    exp_we = 1'b0; start_v = '0;
    store(32'd9, 32'haa);
    check("we+start pass0", 32'(pass_o[0]), 1);

    // Data mismatch, first error sticks.
    do_reset();
    load(1'b0, 32'd7, 32'h05ff_05ff);
    go(0);
    store(32'd7, 32'h1);
    check("t4 fail0", 32'(fail_o[0]), 1);
    check("t4 code0", 32'(code_o[0]), 1);
    check("t4 addr0", faddr_o[0], 32'd7);
    check("t4 data0", fdata_o[0], 32'h1);
    store(32'd7, 32'h05ff_05ff);
    check("t4 sticky data0", fdata_o[0], 32'h1);
    check("t4 sticky pass0", 32'(pass_o[0]), 0);

    // Ordered, out-of-order store ignored.
    do_reset();
    load_tab();
    go(1);
    store(32'd104, 32'd26);
    check("t2 mc1 a", 32'(mc_o[1]), 0);
    store(32'd100, 32'd25);
    check("t2 mc1 b", 32'(mc_o[1]), 1);
    check("t2 pass1", 32'(pass_o[1]), 0);
    check("t2 busy1", 32'(busy_o[1]), 1);

    // Unordered; repeat of an already-hit store counts as stray.
    do_reset();
    load_tab();
    go(2);
    store(32'd104, 32'd26);
    check("t3 mc2 a", 32'(mc_o[2]), 1);
    store(32'd104, 32'd26);
    check("t3 mc2 dup", 32'(mc_o[2]), 1);
    check("t3 fail2 dup", 32'(fail_o[2]), 0);
    store(32'd100, 32'd25);
    check("t3 pass2", 32'(pass_o[2]), 1);

    // Stray store fails when enabled.
    do_reset();
    load_tab();
    go(3);
    store(32'd96, 32'd5);
    check("t5 fail3", 32'(fail_o[3]), 1);
    check("t5 code3", 32'(code_o[3]), 2);
    check("t5 addr3", faddr_o[3], 32'd96);
    check("t5 data3", fdata_o[3], 32'd5);

    // Timeout lands exactly 50 cycles after start.
    do_reset();
    go(3);
    repeat (49) tick();
    check("to fail3 early", 32'(fail_o[3]), 0);
    check("to busy3 early", 32'(busy_o[3]), 1);
    tick();
    check("to fail3", 32'(fail_o[3]), 1);
    check("to code3", 32'(code_o[3]), 3);
    check("to addr3", faddr_o[3], 32'd0);

    // Restart beats a same-cycle store; reset aborts mid-run; full rerun passes.
    do_reset();
    load_tab();
    go(1);
    store(32'd100, 32'd25);
    check("t6 mc1 a", 32'(mc_o[1]), 1);
    start_v[1] = 1'b1; MemWrite = 1'b1; DataAdr = 32'd104; WriteData = 32'd26;
    tick();
    start_v = '0; MemWrite = 1'b0;
    check("t6 restart mc1", 32'(mc_o[1]), 0);
    check("t6 restart pass1", 32'(pass_o[1]), 0);
    store(32'd100, 32'd25);
    do_reset();
    check("t6 rst busy1", 32'(busy_o[1]), 0);
    check("t6 rst mc1", 32'(mc_o[1]), 0);
    check("t6 rst pass1", 32'(pass_o[1]), 0);
    check("t6 rst fail1", 32'(fail_o[1]), 0);
    load_tab();
    go(1);
    store(32'd100, 32'd25);
    store(32'd104, 32'd26);
    check("t6 pass1", 32'(pass_o[1]), 1);
    check("t6 mc1", 32'(mc_o[1]), 2);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
